// File: rtl/nrdiv_seq_ctrl_if.sv
// Request/result bundle between a requesting unit and the divide controller.
interface nrdiv_seq_ctrl_if #(
    parameter int W = 24
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/nrdiv_seq_ctrl.sv
// Iterative unsigned non-restoring divider, one quotient bit per clock.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; also finishes a pending divide-by-zero
//   RUN    | one shift/add-or-subtract step per clock, W steps in total
//   FIX    | final remainder correction, publish result, pulse done
module nrdiv_seq_ctrl #(
    parameter int W  = 24,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    nrdiv_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W:0]    a_q, a_d;
    logic [W-1:0]  q_q, q_d;
    logic [W:0]    m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_pend_q, dbz_pend_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;

    // A is one bit wider than the operands so the partial remainder stays in
    // [-M, M) after every step even for a full-range divisor.
    logic [W:0] a_sh;
    logic [W:0] a_step;
    logic [W:0] a_fix;

    // Datapath for one non-restoring step and the final correction.
    always_comb begin
        a_sh   = {a_q[W-1:0], q_q[W-1]};
        a_step = a_q[W] ? (a_sh + m_q) : (a_sh - m_q);
        a_fix  = a_q[W] ? (a_q + m_q) : a_q;
    end

    // Next-state and result logic.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        dbz_pend_d = 1'b0;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (dbz_pend_q) begin
                    // Divide-by-zero: dividend was parked in Q at acceptance.
                    done_d = 1'b1;
                    dbz_d  = 1'b1;
                    quot_d = '1;
                    rem_d  = q_q;
                end else if (bus.start) begin
                    q_d = bus.dividend;
                    if (bus.divisor != '0) begin
                        a_d     = '0;
                        m_d     = {1'b0, bus.divisor};
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        dbz_pend_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                a_d   = a_step;
                q_d   = {q_q[W-2:0], ~a_step[W]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                a_d     = a_fix;
                quot_d  = q_q;
                rem_d   = a_fix[W-1:0];
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, working registers and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            dbz_pend_q <= dbz_pend_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.done      = done_q;
    assign bus.dbz       = dbz_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_nrdiv_seq_ctrl.sv
// Directed and random checks for the iterative divide controller.
module tb_nrdiv_seq_ctrl;

    localparam int W = 24;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    int   lat;
    logic busy_first;
    logic busy_any;
    logic busy_last;
    logic busy_at_done;
    logic done_first;
    logic [W-1:0] q_mid;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic seen_done;

    nrdiv_seq_ctrl_if #(.W(W)) bus ();

    nrdiv_seq_ctrl #(.W(W), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request from the current time, waits for done (bounded),
    // optionally injects a second start with other operands inject_at clocks
    // after acceptance. Returns in the done cycle, #1 after its edge.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = b + 24'd3;
        busy_first   = bus.busy;
        done_first   = bus.done;
        busy_any     = bus.busy;
        busy_last    = bus.busy;
        q_mid        = bus.quotient;
        lat          = 0;
        seen_done    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (lat == inject_at) begin
                bus.start    = 1'b1;
                bus.dividend = 24'd50;
                bus.divisor  = 24'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            if (lat == 12) q_mid = bus.quotient;
            if (bus.done) begin
                seen_done    = 1'b1;
                busy_at_done = bus.busy;
                break;
            end
            busy_last = bus.busy;
            if (bus.busy) busy_any = 1'b1;
        end
        if (!seen_done) chk("done_timeout", bus.done, 1);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        busy_at_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quot", bus.quotient, 0);
        chk("rst_rem", bus.remainder, 0);
        chk("rst_dbz", bus.dbz, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 100 / 7
        do_div(24'd100, 24'd7, -1);
        chk("t1_lat", lat, 25);
        chk("t1_quot", bus.quotient, 14);
        chk("t1_rem", bus.remainder, 2);
        chk("t1_dbz", bus.dbz, 0);
        chk("t1_busy_first", busy_first, 1);
        chk("t1_busy_last", busy_last, 1);
        chk("t1_busy_at_done", busy_at_done, 0);
        chk("t1_done_first", done_first, 0);
        @(posedge clk);
        #1;
        chk("t1_done_one_cycle", bus.done, 0);

        // Full-range operands
        do_div(24'hFFFFFF, 24'd1, -1);
        chk("t2a_quot", bus.quotient, 24'hFFFFFF);
        chk("t2a_rem", bus.remainder, 0);
        do_div(24'hFFFFFF, 24'hFFFFFF, -1);
        chk("t2b_quot", bus.quotient, 1);
        chk("t2b_rem", bus.remainder, 0);

        // Divisor larger than dividend: final correction path
        do_div(24'd5, 24'd9, -1);
        chk("t3_quot", bus.quotient, 0);
        chk("t3_rem", bus.remainder, 5);
        chk("t3_dbz", bus.dbz, 0);

        // Divide by zero
        do_div(24'd1234, 24'd0, -1);
        chk("t4_lat", lat, 1);
        chk("t4_dbz", bus.dbz, 1);
        chk("t4_quot", bus.quotient, 24'hFFFFFF);
        chk("t4_rem", bus.remainder, 1234);
        chk("t4_busy_first", busy_first, 0);
        chk("t4_busy_any", busy_any, 0);
        chk("t4_busy_at_done", busy_at_done, 0);
        @(posedge clk);
        #1;
        chk("t4_done_one_cycle", bus.done, 0);

        // Start mid-run ignored; start in the done cycle accepted
        do_div(24'd100, 24'd7, 5);
        chk("t5_lat", lat, 25);
        chk("t5_quot", bus.quotient, 14);
        chk("t5_rem", bus.remainder, 2);
        chk("t5_dbz_cleared", bus.dbz, 0);
        do_div(24'd1000, 24'd10, -1);
        chk("t5b_done_first", done_first, 0);
        chk("t5b_held_quot", q_mid, 14);
        chk("t5b_lat", lat, 25);
        chk("t5b_quot", bus.quotient, 100);
        chk("t5b_rem", bus.remainder, 0);

        // Reset during RUN
        bus.start    = 1'b1;
        bus.dividend = 24'd100;
        bus.divisor  = 24'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done", bus.done, 0);
        chk("t6_rst_quot", bus.quotient, 0);
        chk("t6_rst_rem", bus.remainder, 0);
        chk("t6_rst_dbz", bus.dbz, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        chk("t6_no_done", seen_done, 0);
        do_div(24'd999, 24'd13, -1);
        chk("t6_quot", bus.quotient, 76);
        chk("t6_rem", bus.remainder, 11);

        // Random sweep against integer division
        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            if (k % 2 == 0) rb = W'($urandom);
            else            rb = W'($urandom_range(1, 300));
            if (rb == '0) rb = 24'd1;
            do_div(ra, rb, -1);
            chk("rnd_quot", bus.quotient, ra / rb);
            chk("rnd_rem", bus.remainder, ra % rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
